// File: rtl/clock24_pkg.sv
// clock24_pkg
//   Shared constants for the 24-hour timekeeping core: mode encodings
//   reported on the Mode output and the BCD limit of each time field.
package clock24_pkg;

    // Mode encodings. Value 2'd3 is never entered.
    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;

    // Inclusive upper limit of each field, as a BCD digit pair.
    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

endpackage

// File: rtl/bcd_pair_counter.sv
// bcd_pair_counter
//   Two-digit BCD counter that wraps from MAX to 00.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (loads INIT)
//     inc          advance by one (units 9 -> 0 carries into tens)
//     clr          force 00; overrides inc
//     tens, units  registered BCD digits
//     carry        combinational: inc asserted while the pair equals MAX
module bcd_pair_counter #(
    parameter logic [7:0] MAX  = 8'h59,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       at_max;

    // The limit is compared on the whole pair so that e.g. hours 23
    // wraps while 19 -> 20 still takes the normal unit wrap.
    assign at_max = ({tens_q, units_q} == MAX);
    assign carry  = inc & at_max;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = 4'd0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= INIT[7:4];
            units_q <= INIT[3:0];
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/clock24_counter.sv
// clock24_counter
//   Timekeeping core of the 24-hour clock. Counts rising edges of the
//   divided TickIn as seconds in RUN, and lets the user set hours and
//   minutes through a three-state mode machine.
//   Ports:
//     ClkIn            system clock
//     reset            asynchronous, active-low reset
//     TickIn           divided square wave (already in ClkIn domain)
//     ModeBtn, IncBtn  single-cycle button pulses
//     HrT..SecU        registered BCD digits
//     Mode             0 RUN, 1 SET_HR, 2 SET_MIN
//     SecPulse         one-cycle pulse per counted second in RUN
module clock24_counter
    import clock24_pkg::*;
#(
    parameter logic [7:0] INIT_HR  = 8'h00,
    parameter logic [7:0] INIT_MIN = 8'h00
) (
    input  logic       ClkIn,
    input  logic       reset,
    input  logic       TickIn,
    input  logic       ModeBtn,
    input  logic       IncBtn,
    output logic [3:0] HrT,
    output logic [3:0] HrU,
    output logic [3:0] MinT,
    output logic [3:0] MinU,
    output logic [3:0] SecT,
    output logic [3:0] SecU,
    output logic [1:0] Mode,
    output logic       SecPulse
);

    logic       tick_prev_q, tick_prev_d;
    logic [1:0] mode_q, mode_d;
    logic       sec_pulse_q, sec_pulse_d;
    logic       tick;
    logic       run, set_hr, set_min;
    logic       sec_inc, sec_clr, min_inc, hr_inc;
    logic       sec_carry, min_carry, hr_carry;

    // The divider resets its output high, so the previous sample starts
    // high too: a TickIn already high out of reset is not an edge.
    assign tick = TickIn & ~tick_prev_q;

    assign run     = (mode_q == MODE_RUN);
    assign set_hr  = (mode_q == MODE_SET_HR);
    assign set_min = (mode_q == MODE_SET_MIN);

    // Field steering. A ModeBtn in the same cycle drops IncBtn; in RUN the
    // tick is still applied while the mode advances.
    assign sec_inc = run & tick;
    assign sec_clr = set_min & ModeBtn;
    assign min_inc = run ? sec_carry : (set_min & IncBtn & ~ModeBtn);
    assign hr_inc  = run ? min_carry : (set_hr & IncBtn & ~ModeBtn);

    always_comb begin
        tick_prev_d = TickIn;
        sec_pulse_d = sec_inc;
        mode_d      = mode_q;
        case (mode_q)
            MODE_RUN:     if (ModeBtn) mode_d = MODE_SET_HR;
            MODE_SET_HR:  if (ModeBtn) mode_d = MODE_SET_MIN;
            MODE_SET_MIN: if (ModeBtn) mode_d = MODE_RUN;
            default:      mode_d = MODE_RUN;
        endcase
    end

    always_ff @(posedge ClkIn or negedge reset) begin
        if (!reset) begin
            tick_prev_q <= 1'b1;
            mode_q      <= MODE_RUN;
            sec_pulse_q <= 1'b0;
        end else begin
            tick_prev_q <= tick_prev_d;
            mode_q      <= mode_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    bcd_pair_counter #(.MAX(SEC_MAX), .INIT(8'h00)) u_sec (
        .clk(ClkIn), .rst_n(reset), .inc(sec_inc), .clr(sec_clr),
        .tens(SecT), .units(SecU), .carry(sec_carry)
    );

    bcd_pair_counter #(.MAX(MIN_MAX), .INIT(INIT_MIN)) u_min (
        .clk(ClkIn), .rst_n(reset), .inc(min_inc), .clr(1'b0),
        .tens(MinT), .units(MinU), .carry(min_carry)
    );

    // Hours wrap 23 -> 00 without further carry.
    bcd_pair_counter #(.MAX(HR_MAX), .INIT(INIT_HR)) u_hr (
        .clk(ClkIn), .rst_n(reset), .inc(hr_inc), .clr(1'b0),
        .tens(HrT), .units(HrU), .carry(hr_carry)
    );

    assign Mode     = mode_q;
    assign SecPulse = sec_pulse_q;

    logic unused_ok;
    assign unused_ok = hr_carry;

endmodule

// File: tb/tb_clock24_counter.sv
// tb_clock24_counter
//   Self-checking bench for clock24_counter: directed scenarios followed by
//   random buttons/ticks, checked every cycle against a time-in-seconds model.
module tb_clock24_counter;

    logic       ClkIn = 1'b0;
    logic       reset, TickIn, ModeBtn, IncBtn;
    logic [3:0] HrT, HrU, MinT, MinU, SecT, SecU;
    logic [1:0] Mode;
    logic       SecPulse;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_hr, m_min, m_sec, m_mode;
    bit m_prev, m_pulse;

    clock24_counter dut (
        .ClkIn(ClkIn), .reset(reset), .TickIn(TickIn),
        .ModeBtn(ModeBtn), .IncBtn(IncBtn),
        .HrT(HrT), .HrU(HrU), .MinT(MinT), .MinU(MinU),
        .SecT(SecT), .SecU(SecU), .Mode(Mode), .SecPulse(SecPulse)
    );

    always #5 ClkIn = ~ClkIn;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int hms();
        return (bcd(m_hr) << 16) | (bcd(m_min) << 8) | bcd(m_sec);
    endfunction

    function automatic int dut_hms();
        return int'({HrT, HrU, MinT, MinU, SecT, SecU});
    endfunction

    task automatic model_reset();
        m_hr = 0; m_min = 0; m_sec = 0; m_mode = 0;
        m_prev = 1'b1; m_pulse = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs as driven.
    task automatic model_edge();
        bit t;
        int s;
        t       = TickIn && !m_prev;
        m_prev  = TickIn;
        m_pulse = 1'b0;
        case (m_mode)
            0: begin
                if (t) begin
                    s       = (m_hr * 3600 + m_min * 60 + m_sec + 1) % 86400;
                    m_hr    = s / 3600;
                    m_min   = (s / 60) % 60;
                    m_sec   = s % 60;
                    m_pulse = 1'b1;
                end
                if (ModeBtn) m_mode = 1;
            end
            1: begin
                if (ModeBtn) m_mode = 2;
                else if (IncBtn) m_hr = (m_hr + 1) % 24;
            end
            default: begin
                if (ModeBtn) begin
                    m_mode = 0;
                    m_sec  = 0;
                end else if (IncBtn) m_min = (m_min + 1) % 60;
            end
        endcase
    endtask

    task automatic check_all();
        chk("hms",   dut_hms(),     hms());
        chk("mode",  int'(Mode),    m_mode);
        chk("pulse", int'(SecPulse), int'(m_pulse));
    endtask

    task automatic step();
        @(posedge ClkIn);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic press_mode();
        ModeBtn = 1'b1; step(); ModeBtn = 1'b0;
    endtask

    task automatic press_inc();
        IncBtn = 1'b1; step(); IncBtn = 1'b0;
    endtask

    task automatic tick_once();
        TickIn = 1'b0; step();
        TickIn = 1'b1; step();
    endtask

    initial begin
        reset = 1'b0; TickIn = 1'b1; ModeBtn = 1'b0; IncBtn = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("reset_hms", dut_hms(), 0);
        reset = 1'b1;

        // First rising edge counts one cycle after it is presented.
        TickIn = 1'b0; step();
        TickIn = 1'b1; step();
        chk("first_tick", dut_hms(), 24'h000001);
        chk("first_pulse", int'(SecPulse), 1);

        // Set 23:59, then count up to the full rollover.
        press_mode();
        repeat (23) press_inc();
        press_mode();
        repeat (59) press_inc();
        press_mode();
        chk("set_time", dut_hms(), 24'h235900);
        repeat (59) tick_once();
        chk("pre_roll", dut_hms(), 24'h235959);
        TickIn = 1'b0; step();
        TickIn = 1'b1; step();
        chk("rollover", dut_hms(), 24'h000000);
        chk("roll_pulse", int'(SecPulse), 1);
        step();
        chk("pulse_one_cycle", int'(SecPulse), 0);

        // SET_HR: ticks ignored, hours wrap 23 -> 00 without carry.
        press_mode();
        repeat (3) tick_once();
        repeat (23) press_inc();
        chk("hr_at_23", dut_hms(), 24'h230000);
        press_inc();
        chk("hr_wrap", dut_hms(), 24'h000000);

        // Mode and Inc together: mode wins, hours untouched.
        ModeBtn = 1'b1; IncBtn = 1'b1; step();
        ModeBtn = 1'b0; IncBtn = 1'b0;
        chk("mode_inc_mode", int'(Mode), 2);
        chk("mode_inc_hr", int'({HrT, HrU}), 0);

        // SET_MIN: minutes wrap 59 -> 00, hours unaffected.
        repeat (59) press_inc();
        repeat (2) tick_once();
        press_inc();
        chk("min_wrap", dut_hms(), 24'h000000);
        press_mode();

        // TickIn held high counts once.
        TickIn = 1'b0; step();
        TickIn = 1'b1;
        repeat (100) step();
        chk("hold_high", dut_hms(), 24'h000001);

        // Tick and ModeBtn together at 00:00:10.
        repeat (9) tick_once();
        chk("at_10", dut_hms(), 24'h000010);
        TickIn = 1'b0; step();
        TickIn = 1'b1; ModeBtn = 1'b1; step(); ModeBtn = 1'b0;
        chk("coin_hms", dut_hms(), 24'h000011);
        chk("coin_mode", int'(Mode), 1);
        press_mode();
        press_mode();

        // Reach 12:34:56, then reset asynchronously mid-cycle.
        press_mode();
        repeat (12) press_inc();
        press_mode();
        repeat (34) press_inc();
        press_mode();
        repeat (56) tick_once();
        chk("pre_reset", dut_hms(), 24'h123456);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_hms", dut_hms(), 0);
        chk("async_reset_mode", int'(Mode), 0);
        chk("async_reset_pulse", int'(SecPulse), 0);
        model_reset();
        #2 reset = 1'b1;
        repeat (3) step();
        chk("no_tick_after_reset", dut_hms(), 0);

        // Random buttons and tick toggling (period never below 2 cycles).
        repeat (3000) begin
            TickIn  = 1'($urandom_range(0, 1));
            ModeBtn = ($urandom_range(0, 15) == 0);
            IncBtn  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
